// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: states, opcodes,
// ALU/mux select codes and the bundled control-output struct.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [1:0] alu_op;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational decode from the current control state to every datapath
// enable and mux select; pc_en folds in the branch zero flag.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic pc_write;
  logic pc_write_cond;

  always_comb begin
    ctrl_o        = '0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        pc_write         = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut here.
        ctrl_o.alu_src_b  = SRCB_IMM_SH;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal_op = !op_is_legal(opcode_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_REG;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.pc_src    = PCSRC_ALUOUT;
        pc_write_cond    = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src = PCSRC_JUMP;
        pc_write      = 1'b1;
      end
      S_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      default: ;
    endcase
    ctrl_o.pc_en = pc_write | (pc_write_cond & zero_i);
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: state register,
// next-state sequencing with memory-ready stalls, and reset output gating.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] opcode,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            pc_en,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            ir_write,
  output logic            reg_dst,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            alu_src_a,
  output logic            alu_src_b_sel1,
  output logic            alu_src_b_sel2,
  output logic            pc_src_sel1,
  output logic            pc_src_sel2,
  output logic [1:0]      alu_op,
  output logic            illegal_op,
  output logic [ST_W-1:0] state
);

  state_e state_q, state_d;
  logic   run_q;
  ctrl_t  ctrl_raw, ctrl;

  // run_q keeps outputs quiet until the first edge after reset release, and
  // drops them asynchronously the moment reset asserts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (run_q) begin
      case (state_q)
        S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:     state_d = S_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BRANCH;
            OP_J:         state_d = S_JUMP;
            OP_ADDI:      state_d = S_ADDI_EX;
            default:      state_d = S_FETCH;
          endcase
        end
        S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
        S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
        S_EXEC:     state_d = S_R_WB;
        S_BRANCH:   state_d = S_FETCH;
        S_JUMP:     state_d = S_FETCH;
        S_ADDI_EX:  state_d = S_ADDI_WB;
        default:    state_d = S_FETCH;
      endcase
    end
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  assign ctrl = run_q ? ctrl_raw : '0;

  assign pc_en          = ctrl.pc_en;
  assign i_or_d         = ctrl.i_or_d;
  assign mem_read       = ctrl.mem_read;
  assign mem_write      = ctrl.mem_write;
  assign ir_write       = ctrl.ir_write;
  assign reg_dst        = ctrl.reg_dst;
  assign mem_to_reg     = ctrl.mem_to_reg;
  assign reg_write      = ctrl.reg_write;
  assign alu_src_a      = ctrl.alu_src_a;
  assign alu_src_b_sel1 = ctrl.alu_src_b[1];
  assign alu_src_b_sel2 = ctrl.alu_src_b[0];
  assign pc_src_sel1    = ctrl.pc_src[1];
  assign pc_src_sel2    = ctrl.pc_src[0];
  assign alu_op         = ctrl.alu_op;
  assign illegal_op     = ctrl.illegal_op;
  assign state          = ST_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: directed cycle table, async reset case,
// and randomized instruction streams checked against a phase-list model.
module tb_mips_multicycle_ctrl;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst;
  logic       mem_to_reg, reg_write, alu_src_a;
  logic       alu_src_b_sel1, alu_src_b_sel2, pc_src_sel1, pc_src_sel2;
  logic [1:0] alu_op;
  logic       illegal_op;
  logic [3:0] state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.OP_W(6), .ST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b_sel1(alu_src_b_sel1), .alu_src_b_sel2(alu_src_b_sel2),
    .pc_src_sel1(pc_src_sel1), .pc_src_sel2(pc_src_sel2),
    .alu_op(alu_op), .illegal_op(illegal_op), .state(state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pc_en, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] src_b, pc_src, alu_op;
    logic       illegal;
  } outs_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
  endfunction

  // Expected outputs for one cycle spent in phase ph (numbered as the state codes).
  function automatic outs_t model_outs(input int ph, input bit mr, input bit z, input bit legal);
    outs_t o;
    o = '0;
    case (ph)
      0:  begin o.mem_read = 1; o.src_b = 2'b01; o.ir_write = mr; o.pc_en = mr; end
      1:  begin o.src_b = 2'b11; o.illegal = !legal; end
      2:  begin o.alu_src_a = 1; o.src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.i_or_d = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      5:  begin o.mem_write = 1; o.i_or_d = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1; end
      8:  begin o.alu_src_a = 1; o.alu_op = 2'b01; o.pc_src = 2'b01; o.pc_en = z; end
      9:  begin o.pc_en = 1; o.pc_src = 2'b10; end
      10: begin o.alu_src_a = 1; o.src_b = 2'b10; end
      11: begin o.reg_write = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t act_outs();
    outs_t o;
    o.pc_en = pc_en; o.i_or_d = i_or_d; o.mem_read = mem_read; o.mem_write = mem_write;
    o.ir_write = ir_write; o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg;
    o.reg_write = reg_write; o.alu_src_a = alu_src_a;
    o.src_b = {alu_src_b_sel1, alu_src_b_sel2};
    o.pc_src = {pc_src_sel1, pc_src_sel2};
    o.alu_op = alu_op; o.illegal = illegal_op;
    return o;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic [5:0] op, input logic mr, input logic z);
    @(negedge clk);
    opcode = op; mem_ready = mr; zero = z;
    #1;
  endtask

  task automatic check_invariants();
    check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
    check("rw_pc_excl", 32'(reg_write & pc_en), 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1;
    #1;
    check("reset_state", 32'(state), 32'd0);
    check("reset_outs", 32'(act_outs()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_quiet", 32'(act_outs()), 32'd0);
  endtask

  // ---------------- directed table ----------------
  // key = {pc_en, reg_write, mem_read, mem_write, illegal_op}
  typedef struct {
    logic [5:0] op;
    logic       mr, z;
    logic [3:0] st;
    logic [4:0] key;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic [5:0] op, input logic mr, input logic z,
                              input logic [3:0] st, input logic [4:0] key);
    vec_t v;
    v.op = op; v.mr = mr; v.z = z; v.st = st; v.key = key;
    return v;
  endfunction

  // ---------------- random scoreboard ----------------
  typedef struct packed { logic [5:0] op; logic mr; logic z; } stim_t;
  stim_t      stim_q[$];
  logic [19:0] exp_q[$];

  task automatic build_instr(input logic [5:0] op);
    int    ph_list[$];
    bit    legal;
    int    stalls;
    stim_t s;
    legal = is_legal(op);
    case (op)
      6'b000000: ph_list = '{0, 1, 6, 7};
      6'b100011: ph_list = '{0, 1, 2, 3, 4};
      6'b101011: ph_list = '{0, 1, 2, 5};
      6'b000100: ph_list = '{0, 1, 8};
      6'b000010: ph_list = '{0, 1, 9};
      6'b001000: ph_list = '{0, 1, 10, 11};
      default:   ph_list = '{0, 1};
    endcase
    foreach (ph_list[k]) begin
      if (ph_list[k] inside {0, 3, 5}) begin
        stalls = $urandom_range(0, 3);
        for (int n = 0; n < stalls; n++) begin
          s.op = op; s.mr = 1'b0; s.z = 1'($urandom);
          stim_q.push_back(s);
          exp_q.push_back({4'(ph_list[k]), model_outs(ph_list[k], 1'b0, s.z, legal)});
        end
        s.mr = 1'b1;
      end else begin
        s.mr = 1'($urandom);
      end
      s.op = op; s.z = 1'($urandom);
      stim_q.push_back(s);
      exp_q.push_back({4'(ph_list[k]), model_outs(ph_list[k], s.mr, s.z, legal)});
    end
  endtask

  // ---------------- test sequence ----------------
  logic [5:0] legal_ops[6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};

  initial begin
    vec_t        v;
    outs_t       a;
    logic [19:0] e;
    stim_t       s;
    logic [5:0]  op;

    // lw, mem_ready tied high
    tbl.push_back(mk(6'b100011, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b100011, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b100011, 1, 0, 2, 5'b00000));
    tbl.push_back(mk(6'b100011, 1, 0, 3, 5'b00100));
    tbl.push_back(mk(6'b100011, 1, 0, 4, 5'b01000));
    // sw with three wait cycles in MEM_WR
    tbl.push_back(mk(6'b101011, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b101011, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b101011, 1, 0, 2, 5'b00000));
    tbl.push_back(mk(6'b101011, 0, 0, 5, 5'b00010));
    tbl.push_back(mk(6'b101011, 0, 0, 5, 5'b00010));
    tbl.push_back(mk(6'b101011, 0, 0, 5, 5'b00010));
    tbl.push_back(mk(6'b101011, 1, 0, 5, 5'b00010));
    // beq taken, then not taken (zero high outside BRANCH is ignored)
    tbl.push_back(mk(6'b000100, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b000100, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b000100, 1, 1, 8, 5'b10000));
    tbl.push_back(mk(6'b000100, 1, 1, 0, 5'b10100));
    tbl.push_back(mk(6'b000100, 1, 1, 1, 5'b00000));
    tbl.push_back(mk(6'b000100, 1, 0, 8, 5'b00000));
    // j then R-type
    tbl.push_back(mk(6'b000010, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b000010, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b000010, 1, 0, 9, 5'b10000));
    tbl.push_back(mk(6'b000000, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b000000, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b000000, 1, 0, 6, 5'b00000));
    tbl.push_back(mk(6'b000000, 1, 0, 7, 5'b01000));
    // addi with one fetch stall
    tbl.push_back(mk(6'b001000, 0, 0, 0, 5'b00100));
    tbl.push_back(mk(6'b001000, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b001000, 1, 0, 1, 5'b00000));
    tbl.push_back(mk(6'b001000, 1, 0, 10, 5'b00000));
    tbl.push_back(mk(6'b001000, 1, 0, 11, 5'b01000));
    // illegal opcode: one-cycle pulse, straight back to FETCH
    tbl.push_back(mk(6'b111111, 1, 0, 0, 5'b10100));
    tbl.push_back(mk(6'b111111, 1, 0, 1, 5'b00001));
    tbl.push_back(mk(6'b111111, 1, 0, 0, 5'b10100));

    apply_reset();

    foreach (tbl[i]) begin
      v = tbl[i];
      drive_cycle(v.op, v.mr, v.z);
      a = act_outs();
      check($sformatf("tbl%0d_state", i), 32'(state), 32'(v.st));
      check($sformatf("tbl%0d_key", i),
            32'({a.pc_en, a.reg_write, a.mem_read, a.mem_write, a.illegal}), 32'(v.key));
      check($sformatf("tbl%0d_outs", i), 32'(a),
            32'(model_outs(int'(v.st), v.mr, v.z, is_legal(v.op))));
      check_invariants();
    end

    // Reset asserted mid MEM_RD wait: state and mem_read drop without an edge.
    apply_reset();
    drive_cycle(6'b100011, 1, 0);
    drive_cycle(6'b100011, 1, 0);
    drive_cycle(6'b100011, 1, 0);
    drive_cycle(6'b100011, 0, 0);
    check("memrd_state", 32'(state), 32'd3);
    check("memrd_read", 32'(mem_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_mem_read", 32'(mem_read), 32'd0);
    check("async_outs", 32'(act_outs()), 32'd0);
    @(negedge clk);
    check("held_outs", 32'(act_outs()), 32'd0);
    rst_n = 1'b1;

    // Randomized instruction stream.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      build_instr(op);
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      drive_cycle(s.op, s.mr, s.z);
      check("rand_cycle", 32'({state, act_outs()}), 32'(e));
      check_invariants();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
